// File: rtl/descramble_multi.sv
// Self-synchronising 64b/66b receive descrambler (x^58 + x^39 + 1) for a 64- or 32-bit datapath.
// Two-stage pipeline with runtime bypass, lock indication and a saturating sync-header error counter.
module descramble_multi #(
    parameter int          DATA_W   = 64,
    parameter int          CNT_W    = 16,
    parameter logic [57:0] RST_SEED = 58'd0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [1:0]        head_i,
    input  logic              head_vld_i,
    input  logic              data_vld_i,
    input  logic              bypass_i,
    input  logic              clear_i,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        head_o,
    output logic              head_vld_o,
    output logic              data_vld_o,
    output logic              locked_o,
    output logic [CNT_W-1:0]  hdr_err_cnt_o
);

    localparam int         EXT_W     = DATA_W + 58;
    localparam logic [6:0] WORD_BITS = 7'(DATA_W);
    localparam logic [6:0] LOCK_BITS = 7'd58;

    if (DATA_W != 64 && DATA_W != 32) begin : g_bad_width
        $error("descramble_multi: DATA_W must be 64 or 32");
    end

    logic [DATA_W-1:0] in_data_q;
    logic [1:0]        in_head_q;
    logic              in_hvld_q;
    logic              in_dvld_q;
    logic              in_byp_q;

    logic [57:0]       scr_q, scr_d;
    logic [6:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        bit_sum;
    logic              locked_q, locked_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic              hdr_bad;

    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [1:0]        out_head_q;
    logic              out_hvld_q;
    logic              out_dvld_q;

    logic [EXT_W-1:0]  ext;
    logic [DATA_W-1:0] descr;

    // Received bit stream in wire order: ext[0] is the oldest stored bit,
    // ext[EXT_W-1] is the last bit of the word in the input stage.
    always_comb begin
        ext = '0;
        for (int j = 0; j < 58; j++) begin
            ext[j] = scr_q[57-j];
        end
        ext[EXT_W-1:58] = in_data_q;
    end

    // Bit k of the word sits at ext[k+58]; taps 39 and 58 bits earlier.
    assign descr = in_data_q ^ ext[DATA_W+18:19] ^ ext[DATA_W-1:0];

    always_comb begin
        scr_d = scr_q;
        if (in_dvld_q) begin
            for (int i = 0; i < 58; i++) begin
                scr_d[i] = ext[EXT_W-1-i];
            end
        end
    end

    assign bit_sum = bit_cnt_q + WORD_BITS;

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        locked_d  = locked_q;
        if (clear_i) begin
            bit_cnt_d = '0;
            locked_d  = 1'b0;
        end else if (in_dvld_q) begin
            if (bit_cnt_q == LOCK_BITS) begin
                locked_d = 1'b1;
            end
            bit_cnt_d = (bit_sum >= LOCK_BITS) ? LOCK_BITS : bit_sum;
        end
    end

    assign hdr_bad = in_hvld_q & (in_head_q[1] ~^ in_head_q[0]);

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clear_i) begin
            err_cnt_d = '0;
        end else if (hdr_bad && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        out_data_d = out_data_q;
        if (in_dvld_q) begin
            out_data_d = in_byp_q ? in_data_q : descr;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            in_data_q  <= '0;
            in_head_q  <= '0;
            in_hvld_q  <= 1'b0;
            in_dvld_q  <= 1'b0;
            in_byp_q   <= 1'b0;
            scr_q      <= RST_SEED;
            bit_cnt_q  <= '0;
            locked_q   <= 1'b0;
            err_cnt_q  <= '0;
            out_data_q <= '0;
            out_head_q <= '0;
            out_hvld_q <= 1'b0;
            out_dvld_q <= 1'b0;
        end else begin
            in_data_q  <= data_i;
            in_head_q  <= head_i;
            in_hvld_q  <= head_vld_i;
            in_dvld_q  <= data_vld_i;
            in_byp_q   <= bypass_i;
            scr_q      <= scr_d;
            bit_cnt_q  <= bit_cnt_d;
            locked_q   <= locked_d;
            err_cnt_q  <= err_cnt_d;
            out_data_q <= out_data_d;
            out_head_q <= in_head_q;
            out_hvld_q <= in_hvld_q;
            out_dvld_q <= in_dvld_q;
        end
    end

    assign data_o        = out_data_q;
    assign head_o        = out_head_q;
    assign head_vld_o    = out_hvld_q;
    assign data_vld_o    = out_dvld_q;
    assign locked_o      = locked_q;
    assign hdr_err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_descramble_multi.sv
// Bench for descramble_multi: 64-bit, 32-bit and 2-bit-counter instances checked every cycle
// against a bit-serial scrambler/descrambler model, plus literal expectations.
module tb_descramble_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i, clear_i, bypass_i;
    logic [63:0] a_data_i;
    logic [1:0]  a_head_i;
    logic        a_hvld_i, a_dvld_i;
    logic [31:0] b_data_i;
    logic [1:0]  b_head_i;
    logic        b_hvld_i, b_dvld_i;

    logic [63:0] a_data_o, c_data_o;
    logic [31:0] b_data_o;
    logic [1:0]  a_head_o, b_head_o, c_head_o;
    logic        a_hvld_o, b_hvld_o, c_hvld_o;
    logic        a_dvld_o, b_dvld_o, c_dvld_o;
    logic        a_lock_o, b_lock_o, c_lock_o;
    logic [15:0] a_err_o, b_err_o;
    logic [1:0]  c_err_o;

    localparam logic [57:0] SEED_B = {2'b10, 56'hBCDE_F012_3456_78};

    descramble_multi #(.DATA_W(64), .CNT_W(16), .RST_SEED(58'd0)) u_a (
        .clk_i(clk), .rst_i(rst_i), .data_i(a_data_i), .head_i(a_head_i),
        .head_vld_i(a_hvld_i), .data_vld_i(a_dvld_i), .bypass_i(bypass_i), .clear_i(clear_i),
        .data_o(a_data_o), .head_o(a_head_o), .head_vld_o(a_hvld_o), .data_vld_o(a_dvld_o),
        .locked_o(a_lock_o), .hdr_err_cnt_o(a_err_o));

    descramble_multi #(.DATA_W(32), .CNT_W(16), .RST_SEED(SEED_B)) u_b (
        .clk_i(clk), .rst_i(rst_i), .data_i(b_data_i), .head_i(b_head_i),
        .head_vld_i(b_hvld_i), .data_vld_i(b_dvld_i), .bypass_i(bypass_i), .clear_i(clear_i),
        .data_o(b_data_o), .head_o(b_head_o), .head_vld_o(b_hvld_o), .data_vld_o(b_dvld_o),
        .locked_o(b_lock_o), .hdr_err_cnt_o(b_err_o));

    descramble_multi #(.DATA_W(64), .CNT_W(2), .RST_SEED(58'd0)) u_c (
        .clk_i(clk), .rst_i(rst_i), .data_i(a_data_i), .head_i(a_head_i),
        .head_vld_i(a_hvld_i), .data_vld_i(a_dvld_i), .bypass_i(bypass_i), .clear_i(clear_i),
        .data_o(c_data_o), .head_o(c_head_o), .head_vld_o(c_hvld_o), .data_vld_o(c_dvld_o),
        .locked_o(c_lock_o), .hdr_err_cnt_o(c_err_o));

    // Stream 0 feeds u_a and u_c, stream 1 feeds u_b.
    logic [57:0] tx_sh [2];
    logic [57:0] rx_hist [2];
    logic [63:0] drv_data [2];
    logic [63:0] drv_pay [2];
    logic [1:0]  drv_head [2];
    logic        drv_hv [2], drv_dv [2], drv_haspay [2];
    logic        half_b;

    logic [63:0] s1_data [2];
    logic [63:0] s1_pay [2];
    logic [1:0]  s1_head [2];
    logic        s1_hv [2], s1_dv [2], s1_haspay [2];
    logic        s1_byp;

    logic [63:0] e_data [2];
    logic [63:0] e_pay [2];
    logic [1:0]  e_head [2];
    logic        e_hv [2], e_dv [2], e_lock [2], e_paychk [2];
    int          e_err [2];
    int          e_err_c;
    int          words_since [2];
    int          bits_rx [2];

    logic rst_v, clr_v, byp_v;
    bit   chk_en;
    int   n_pass, n_total;

    function automatic int width_of(input int s);
        return (s == 0) ? 64 : 32;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Serial descrambler: h[d-1] is the bit received d bit-times ago.
    task automatic descr_word(input int s, input int w, input logic [63:0] din,
                              output logic [63:0] dout);
        logic [57:0] h;
        h = rx_hist[s];
        dout = '0;
        for (int k = 0; k < w; k++) begin
            dout[k] = din[k] ^ h[38] ^ h[57];
            h = {h[56:0], din[k]};
        end
        rx_hist[s] = h;
    endtask

    // herr: 0 = legal header, 1 = 2'b00, 2 = 2'b11
    task automatic make_word(input int s, input bit vld, input bit raw_en,
                             input logic [63:0] raw, input int herr);
        int          w;
        logic [63:0] mask, p, d;
        logic [57:0] sh;
        w    = width_of(s);
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        if (!vld) begin
            drv_dv[s]     = 1'b0;
            drv_hv[s]     = 1'b0;
            drv_data[s]   = {$urandom, $urandom} & mask;
            drv_head[s]   = 2'($urandom_range(3, 0));
            drv_haspay[s] = 1'b0;
            drv_pay[s]    = '0;
        end else begin
            sh = tx_sh[s];
            p  = '0;
            d  = '0;
            if (raw_en) begin
                d = raw & mask;
                for (int k = 0; k < w; k++) sh = {sh[56:0], d[k]};
            end else begin
                p = {$urandom, $urandom} & mask;
                for (int k = 0; k < w; k++) begin
                    d[k] = p[k] ^ sh[38] ^ sh[57];
                    sh   = {sh[56:0], d[k]};
                end
            end
            tx_sh[s]      = sh;
            drv_dv[s]     = 1'b1;
            drv_data[s]   = d;
            drv_pay[s]    = p;
            drv_haspay[s] = !raw_en;
            if (s == 0) begin
                drv_hv[s] = 1'b1;
            end else begin
                drv_hv[s] = !half_b;
                half_b    = !half_b;
            end
            if (herr == 1)      drv_head[s] = 2'b00;
            else if (herr == 2) drv_head[s] = 2'b11;
            else                drv_head[s] = ($urandom_range(1, 0) == 1) ? 2'b01 : 2'b10;
        end
    endtask

    task automatic model_clock();
        logic [63:0] d;
        bit          bad;
        for (int s = 0; s < 2; s++) begin
            int w;
            w = width_of(s);
            if (rst_v) begin
                s1_data[s] = '0; s1_pay[s] = '0; s1_head[s] = '0;
                s1_hv[s] = 1'b0; s1_dv[s] = 1'b0; s1_haspay[s] = 1'b0;
                e_data[s] = '0; e_pay[s] = '0; e_head[s] = '0;
                e_hv[s] = 1'b0; e_dv[s] = 1'b0; e_lock[s] = 1'b0; e_paychk[s] = 1'b0;
                e_err[s] = 0;
                rx_hist[s] = (s == 0) ? 58'd0 : SEED_B;
                words_since[s] = 0;
                bits_rx[s] = 0;
                if (s == 0) e_err_c = 0;
            end else begin
                e_dv[s]     = s1_dv[s];
                e_hv[s]     = s1_hv[s];
                e_head[s]   = s1_head[s];
                e_paychk[s] = 1'b0;
                if (s1_dv[s]) begin
                    descr_word(s, w, s1_data[s], d);
                    e_data[s]   = s1_byp ? s1_data[s] : d;
                    e_pay[s]    = s1_pay[s];
                    e_paychk[s] = s1_haspay[s] && !s1_byp && (bits_rx[s] >= 58);
                    bits_rx[s] += w;
                end
                if (clr_v) begin
                    e_lock[s] = 1'b0;
                    words_since[s] = 0;
                end else if (s1_dv[s]) begin
                    if (words_since[s] >= (58 + w - 1) / w) e_lock[s] = 1'b1;
                    words_since[s]++;
                end
                bad = s1_hv[s] && (s1_head[s] == 2'b00 || s1_head[s] == 2'b11);
                if (clr_v) begin
                    e_err[s] = 0;
                    if (s == 0) e_err_c = 0;
                end else if (bad) begin
                    if (e_err[s] < 65535) e_err[s]++;
                    if (s == 0 && e_err_c < 3) e_err_c++;
                end
                s1_data[s]   = drv_data[s];
                s1_pay[s]    = drv_pay[s];
                s1_head[s]   = drv_head[s];
                s1_hv[s]     = drv_hv[s];
                s1_dv[s]     = drv_dv[s];
                s1_haspay[s] = drv_haspay[s];
            end
        end
        s1_byp = rst_v ? 1'b0 : byp_v;
    endtask

    task automatic apply();
        rst_i    = rst_v;
        clear_i  = clr_v;
        bypass_i = byp_v;
        a_data_i = drv_data[0];
        a_head_i = drv_head[0];
        a_hvld_i = drv_hv[0];
        a_dvld_i = drv_dv[0];
        b_data_i = drv_data[1][31:0];
        b_head_i = drv_head[1];
        b_hvld_i = drv_hv[1];
        b_dvld_i = drv_dv[1];
    endtask

    task automatic do_cycle();
        apply();
        model_clock();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        make_word(0, 1'b0, 1'b0, 64'd0, 0);
        make_word(1, 1'b0, 1'b0, 64'd0, 0);
        do_cycle();
    endtask

    task automatic rand_cycle(input int gap_pct, input int err_pct, input int clr_pct);
        bit vld;
        int herr;
        for (int s = 0; s < 2; s++) begin
            vld  = ($urandom_range(99, 0) >= gap_pct);
            herr = ($urandom_range(99, 0) < err_pct) ? int'($urandom_range(2, 1)) : 0;
            make_word(s, vld, 1'b0, 64'd0, herr);
        end
        clr_v = ($urandom_range(99, 0) < clr_pct);
        do_cycle();
        clr_v = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_data", a_data_o, e_data[0]);
            chk("a_head", 64'(a_head_o), 64'(e_head[0]));
            chk("a_hvld", 64'(a_hvld_o), 64'(e_hv[0]));
            chk("a_dvld", 64'(a_dvld_o), 64'(e_dv[0]));
            chk("a_lock", 64'(a_lock_o), 64'(e_lock[0]));
            chk("a_err",  64'(a_err_o),  64'(e_err[0]));
            chk("b_data", 64'(b_data_o), e_data[1]);
            chk("b_head", 64'(b_head_o), 64'(e_head[1]));
            chk("b_hvld", 64'(b_hvld_o), 64'(e_hv[1]));
            chk("b_dvld", 64'(b_dvld_o), 64'(e_dv[1]));
            chk("b_lock", 64'(b_lock_o), 64'(e_lock[1]));
            chk("b_err",  64'(b_err_o),  64'(e_err[1]));
            chk("c_data", c_data_o, e_data[0]);
            chk("c_dvld", 64'(c_dvld_o), 64'(e_dv[0]));
            chk("c_lock", 64'(c_lock_o), 64'(e_lock[0]));
            chk("c_err",  64'(c_err_o),  64'(e_err_c));
            if (e_paychk[0]) chk("a_payload", a_data_o, e_pay[0]);
            if (e_paychk[1]) chk("b_payload", 64'(b_data_o), e_pay[1]);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_pass = 0;
        n_total = 0;
        half_b = 1'b0;
        tx_sh[0] = {26'($urandom), $urandom};
        tx_sh[1] = {26'($urandom), $urandom};
        rst_v = 1'b1; clr_v = 1'b0; byp_v = 1'b0;
        chk_en = 1'b1;

        // Reset state
        repeat (3) idle_cycle();
        chk("rst_a_data", a_data_o, 64'd0);
        chk("rst_a_dvld", 64'(a_dvld_o), 64'd0);
        chk("rst_a_lock", 64'(a_lock_o), 64'd0);
        chk("rst_a_err",  64'(a_err_o), 64'd0);
        chk("rst_b_data", 64'(b_data_o), 64'd0);
        chk("rst_b_hvld", 64'(b_hvld_o), 64'd0);
        chk("rst_c_err",  64'(c_err_o), 64'd0);

        // Single raw word into the 64-bit instance with a zero seed
        rst_v = 1'b0;
        make_word(0, 1'b1, 1'b1, 64'h1, 0);
        drv_head[0] = 2'b01;
        make_word(1, 1'b0, 1'b0, 64'd0, 0);
        do_cycle();
        idle_cycle();
        chk("t1_data", a_data_o, 64'h0400_0080_0000_0001);
        chk("t1_head", 64'(a_head_o), 64'd1);
        chk("t1_dvld", 64'(a_dvld_o), 64'd1);
        chk("t1_lock", 64'(a_lock_o), 64'd0);

        // Continuous stream with a bypass window on words 10-19
        rst_v = 1'b1;
        repeat (2) idle_cycle();
        rst_v = 1'b0;
        for (int i = 0; i < 400; i++) begin
            byp_v = (i + 1 >= 10) && (i + 1 <= 19);
            rand_cycle(0, 3, 0);
            if (i == 1) begin
                chk("t2_a_lock_w1", 64'(a_lock_o), 64'd0);
                chk("t2_b_lock_w1", 64'(b_lock_o), 64'd0);
            end
            if (i == 2) begin
                chk("t2_a_lock_w2", 64'(a_lock_o), 64'd1);
                chk("t2_b_lock_w2", 64'(b_lock_o), 64'd0);
            end
            if (i == 3) chk("t2_b_lock_w3", 64'(b_lock_o), 64'd1);
        end
        byp_v = 1'b0;

        // Idle gaps and occasional clears
        for (int i = 0; i < 600; i++) rand_cycle(30, 3, 1);

        // One-cycle reset mid-stream
        make_word(0, 1'b1, 1'b0, 64'd0, 0);
        make_word(1, 1'b1, 1'b0, 64'd0, 0);
        rst_v = 1'b1;
        do_cycle();
        rst_v = 1'b0;
        chk("t6_a_dvld", 64'(a_dvld_o), 64'd0);
        chk("t6_a_data", a_data_o, 64'd0);
        chk("t6_a_lock", 64'(a_lock_o), 64'd0);
        chk("t6_b_dvld", 64'(b_dvld_o), 64'd0);
        chk("t6_b_lock", 64'(b_lock_o), 64'd0);
        for (int i = 0; i < 150; i++) rand_cycle(30, 3, 0);

        // Header error counting and saturation
        rst_v = 1'b1;
        repeat (2) idle_cycle();
        rst_v = 1'b0;
        for (int j = 0; j < 5; j++) begin
            make_word(0, 1'b1, 1'b0, 64'd0, (j < 3) ? 1 : 2);
            make_word(1, 1'b0, 1'b0, 64'd0, 0);
            do_cycle();
        end
        repeat (2) idle_cycle();
        chk("t5_a_err5", 64'(a_err_o), 64'd5);
        chk("t5_c_err_sat", 64'(c_err_o), 64'd3);
        for (int j = 0; j < 5; j++) begin
            make_word(0, 1'b1, 1'b0, 64'd0, 1);
            make_word(1, 1'b0, 1'b0, 64'd0, 0);
            do_cycle();
        end
        repeat (2) idle_cycle();
        chk("t5_a_err10", 64'(a_err_o), 64'd10);
        chk("t5_c_err_hold", 64'(c_err_o), 64'd3);
        make_word(0, 1'b1, 1'b0, 64'd0, 2);
        make_word(1, 1'b0, 1'b0, 64'd0, 0);
        do_cycle();
        clr_v = 1'b1;
        idle_cycle();
        clr_v = 1'b0;
        chk("t5_clr_hvld", 64'(a_hvld_o), 64'd1);
        chk("t5_clr_a_err", 64'(a_err_o), 64'd0);
        chk("t5_clr_c_err", 64'(c_err_o), 64'd0);
        chk("t5_clr_lock", 64'(a_lock_o), 64'd0);
        repeat (3) idle_cycle();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
